fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time to instruction memory and
// presents the returned instruction downstream, with stall, redirect and misalign handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] pc_plus4_r;
    logic [31:0] inst_r, inst_s;
    logic        inst_valid_r, inst_valid_s;
    logic        pend_r, pend_s;
    logic [31:0] pend_pc_r, pend_pc_s;
    logic        misalign_r, misalign_s;
    logic        imem_req_r;
    logic [31:0] redir_pc_s;

    assign redir_pc_s = {redirect_pc[31:2], 2'b00};

    // Next-state and next-register computation for the BOOT/FETCH/ISSUE sequencer.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        inst_s       = inst_r;
        inst_valid_s = inst_valid_r;
        pend_s       = pend_r;
        pend_pc_s    = pend_pc_r;
        misalign_s   = misalign_r;

        if (redirect_valid && (state_r != BOOT) && (redirect_pc[1:0] != 2'b00)) begin
            misalign_s = 1'b1;
        end else begin
            misalign_s = misalign_r;
        end

        case (state_r)
            BOOT: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    // A response to a superseded address is dropped and the fetch restarts.
                    if (pend_r || redirect_valid) begin
                        pc_s   = redirect_valid ? redir_pc_s : pend_pc_r;
                        pend_s = 1'b0;
                    end else begin
                        inst_s       = imem_rdata;
                        inst_valid_s = 1'b1;
                        state_s      = ISSUE;
                    end
                end else if (redirect_valid) begin
                    pend_s    = 1'b1;
                    pend_pc_s = redir_pc_s;
                end else begin
                    state_s = FETCH;
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    inst_valid_s = 1'b0;
                    pc_s         = redir_pc_s;
                    state_s      = FETCH;
                end else if (!stall) begin
                    inst_valid_s = 1'b0;
                    pc_s         = pc_r + 32'd4;
                    state_s      = FETCH;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

    // State and datapath registers; imem_req and pc_plus4 are registered from next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= BOOT;
            pc_r         <= RESET_PC;
            pc_plus4_r   <= RESET_PC + 32'd4;
            inst_r       <= 32'd0;
            inst_valid_r <= 1'b0;
            pend_r       <= 1'b0;
            pend_pc_r    <= 32'd0;
            misalign_r   <= 1'b0;
            imem_req_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            pc_plus4_r   <= pc_s + 32'd4;
            inst_r       <= inst_s;
            inst_valid_r <= inst_valid_s;
            pend_r       <= pend_s;
            pend_pc_r    <= pend_pc_s;
            misalign_r   <= misalign_s;
            imem_req_r   <= (state_s == FETCH);
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign op         = inst_r[31:26];
    assign pc_out     = pc_r;
    assign pc_plus4   = pc_plus4_r;
    assign misalign   = misalign_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: linear stimulus, hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misalign;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .op             (op),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .misalign       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_iv", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc_out, 32'h0000_3000);
        chk("rst_pc4", pc_plus4, 32'h0000_3004);
        chk("rst_mis", {31'd0, misalign}, 32'd0);

        // Zero-wait memory: one instruction every two cycles.
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h3C01_1234;
        tick();
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, 32'h0000_3000);
        chk("boot_iv", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zw_iv", {31'd0, inst_valid}, 32'd1);
            chk("zw_inst", inst, 32'h3C01_1234);
            chk("zw_op", {26'd0, op}, 32'h0000_000F);
            chk("zw_pc", pc_out, 32'h0000_3000 + 32'(i * 4));
            chk("zw_pc4", pc_plus4, 32'h0000_3004 + 32'(i * 4));
            chk("zw_req_lo", {31'd0, imem_req}, 32'd0);
            if (i < 2) begin
                tick();
                chk("zw_iv_lo", {31'd0, inst_valid}, 32'd0);
                chk("zw_req", {31'd0, imem_req}, 32'd1);
                chk("zw_addr", imem_addr, 32'h0000_3004 + 32'(i * 4));
            end
        end

        // Stall 5 cycles in ISSUE at 3008; ready stays high and rdata changes but is ignored.
        stall = 1'b1; imem_rdata = 32'h8C22_0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_iv", {31'd0, inst_valid}, 32'd1);
            chk("st_inst", inst, 32'h3C01_1234);
            chk("st_pc", pc_out, 32'h0000_3008);
            chk("st_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0; imem_ready = 1'b0;
        tick();
        chk("st_rel_req", {31'd0, imem_req}, 32'd1);
        chk("st_rel_addr", imem_addr, 32'h0000_300C);
        chk("st_rel_iv", {31'd0, inst_valid}, 32'd0);

        // Ready delayed 3 cycles: address holds across all four request cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wt_req", {31'd0, imem_req}, 32'd1);
            chk("wt_addr", imem_addr, 32'h0000_300C);
            chk("wt_iv", {31'd0, inst_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        tick();
        chk("wt_iv_hi", {31'd0, inst_valid}, 32'd1);
        chk("wt_inst", inst, 32'h8C22_0010);
        chk("wt_op", {26'd0, op}, 32'h0000_0023);
        chk("wt_pc", pc_out, 32'h0000_300C);

        // Redirects during a FETCH wait: last one wins, returned word discarded.
        imem_ready = 1'b0;
        tick();
        chk("rd_addr0", imem_addr, 32'h0000_3010);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
        tick();
        redirect_pc = 32'h0000_4000;
        tick();
        chk("rd_req_hold", {31'd0, imem_req}, 32'd1);
        chk("rd_addr_hold", imem_addr, 32'h0000_3010);
        redirect_valid = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_drop_iv", {31'd0, inst_valid}, 32'd0);
        chk("rd_drop_inst", inst, 32'h8C22_0010);
        chk("rd_new_req", {31'd0, imem_req}, 32'd1);
        chk("rd_new_addr", imem_addr, 32'h0000_4000);
        imem_rdata = 32'h2001_0001;
        tick();
        chk("rd_iv", {31'd0, inst_valid}, 32'd1);
        chk("rd_inst", inst, 32'h2001_0001);
        chk("rd_pc", pc_out, 32'h0000_4000);
        chk("rd_pc4", pc_plus4, 32'h0000_4004);

        // Redirect wins over stall in ISSUE.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_6000; imem_ready = 1'b0;
        tick();
        chk("rs_iv", {31'd0, inst_valid}, 32'd0);
        chk("rs_req", {31'd0, imem_req}, 32'd1);
        chk("rs_addr", imem_addr, 32'h0000_6000);
        chk("rs_mis", {31'd0, misalign}, 32'd0);
        stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b1;
        tick();
        chk("rs_pc", pc_out, 32'h0000_6000);

        // Misaligned redirect target is truncated and flagged.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4002; imem_ready = 1'b0;
        tick();
        chk("ma_addr", imem_addr, 32'h0000_4000);
        chk("ma_mis", {31'd0, misalign}, 32'd1);
        redirect_valid = 1'b0; imem_ready = 1'b1;
        tick();
        chk("ma_pc", pc_out, 32'h0000_4000);
        chk("ma_sticky", {31'd0, misalign}, 32'd1);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ready = 1'b0;
        tick();
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0; imem_ready = 1'b1;
        tick();
        chk("wr_pc", pc_out, 32'hFFFF_FFFC);
        chk("wr_pc4", pc_plus4, 32'h0000_0000);
        imem_ready = 1'b0;
        tick();
        chk("wr_next_addr", imem_addr, 32'h0000_0000);
        chk("wr_next_req", {31'd0, imem_req}, 32'd1);
        chk("wr_mis_sticky", {31'd0, misalign}, 32'd1);

        // Reset asserted mid-wait drops the request at once; late response ignored.
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", {31'd0, imem_req}, 32'd0);
        chk("ar_pc", pc_out, 32'h0000_3000);
        chk("ar_mis", {31'd0, misalign}, 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        chk("ar_iv", {31'd0, inst_valid}, 32'd0);
        chk("ar_inst", inst, 32'd0);
        rst_n = 1'b1; imem_rdata = 32'h3C01_1234;
        tick();
        chk("ar_re_req", {31'd0, imem_req}, 32'd1);
        chk("ar_re_addr", imem_addr, 32'h0000_3000);
        chk("ar_re_iv", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("ar_re_iv_hi", {31'd0, inst_valid}, 32'd1);
        chk("ar_re_inst", inst, 32'h3C01_1234);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
